// File: rtl/pe_result_drain.sv
// pe_result_drain: snapshots the N x N PE sum array and streams the sums one
// element per beat over a valid/ready handshake, tagged with row/column, and
// pulses done_o once the final beat has been accepted.
//
// Optional build macro: PE_DRAIN_COLMAJOR_EN selects column-major streaming
// order. Without it, elements stream in row-major order. Handshake, latency
// and beat count do not depend on the order.
//
// Handshake: a beat transfers on a rising edge where out_valid & out_ready are
// both high. While out_valid is high and out_ready is low, out_data, out_row,
// out_col and out_last hold their values. out_valid never depends on
// out_ready within a cycle, because every output comes straight from a flop.
module pe_result_drain #(
  parameter int WIDTH = 4,
  parameter int N     = 3,
  parameter int IW    = $clog2(N)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_i,
  input  logic [N*N*(2*WIDTH+1)-1:0]     sums_i,
  output logic                           busy_o,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [2*WIDTH:0]               out_data,
  output logic [IW-1:0]                  out_row,
  output logic [IW-1:0]                  out_col,
  output logic                           out_last,
  output logic                           done_o
);

  localparam int SW = 2*WIDTH + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t               state_q;
  logic [N*N*SW-1:0]    sum_buf_q;
  logic                 out_valid_q;
  logic [SW-1:0]        out_data_q;
  logic [IW-1:0]        out_row_q;
  logic [IW-1:0]        out_col_q;
  logic                 out_last_q;
  logic                 busy_q;
  logic                 done_q;

  logic [IW-1:0]        row_d;
  logic [IW-1:0]        col_d;
  int                   idx_d;
  logic [SW-1:0]        data_d;
  logic                 last_d;

  // Next element position after the one currently presented; both counters
  // wrap at N-1 so no index ever reaches N.
  always_comb begin
    row_d = out_row_q;
    col_d = out_col_q;
`ifdef PE_DRAIN_COLMAJOR_EN
    if (out_row_q == LAST_IDX) begin
      row_d = '0;
      col_d = (out_col_q == LAST_IDX) ? '0 : out_col_q + IW'(1);
    end else begin
      row_d = out_row_q + IW'(1);
    end
`else
    if (out_col_q == LAST_IDX) begin
      col_d = '0;
      row_d = (out_row_q == LAST_IDX) ? '0 : out_row_q + IW'(1);
    end else begin
      col_d = out_col_q + IW'(1);
    end
`endif
  end

  // Fetch the next element's sum from the snapshot buffer and flag (N-1,N-1).
  always_comb begin
    idx_d  = int'(row_d) * N + int'(col_d);
    data_d = '0;
    for (int k = 0; k < N*N; k++) begin
      if (k == idx_d) begin
        data_d = sum_buf_q[k*SW +: SW];
      end
    end
    last_d = (row_d == LAST_IDX) && (col_d == LAST_IDX);
  end

  // Control FSM with the snapshot buffer and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sum_buf_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (load_i) begin
            // Element (0,0) is presented straight from the input so that the
            // first beat appears one cycle after the load.
            sum_buf_q   <= sums_i;
            out_valid_q <= 1'b1;
            out_data_q  <= sums_i[SW-1:0];
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (out_valid_q && out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              out_row_q  <= row_d;
              out_col_q  <= col_d;
              out_data_q <= data_d;
              out_last_q <= last_d;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// Bench for pe_result_drain (WIDTH=4, N=3): a cycle table for the basic pass,
// then a queue-based scoreboard for back-pressure, full-width data, load while
// busy, reset mid-stream and randomized passes.
module tb_pe_result_drain;

  localparam int WIDTH = 4;
  localparam int N     = 3;
  localparam int IW    = $clog2(N);
  localparam int SW    = 2*WIDTH + 1;
  localparam int W     = SW + 2*IW + 1;

  logic              clk;
  logic              rst;
  logic              load_i;
  logic [N*N*SW-1:0] sums_i;
  logic              busy_o;
  logic              out_valid;
  logic              out_ready;
  logic [SW-1:0]     out_data;
  logic [IW-1:0]     out_row;
  logic [IW-1:0]     out_col;
  logic              out_last;
  logic              done_o;

  pe_result_drain #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load_i),
    .sums_i    (sums_i),
    .busy_o    (busy_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .done_o    (done_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  logic [SW-1:0] cur_sums[N*N];
  logic [W-1:0]  exp_q[$];

  task automatic apply_sums();
    for (int k = 0; k < N*N; k++) sums_i[k*SW +: SW] = cur_sums[k];
  endtask

  // Expected beats of one pass: visit order from the chosen traversal,
  // value looked up by (row, col), last only on the final visit.
  task automatic push_pass();
    for (int i = 0; i < N*N; i++) begin
      int r;
      int c;
`ifdef PE_DRAIN_COLMAJOR_EN
      r = i % N;
      c = i / N;
`else
      r = i / N;
      c = i % N;
`endif
      exp_q.push_back({cur_sums[r*N+c], IW'(r), IW'(c), (i == N*N-1)});
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  bit           mon_en    = 0;
  bit           last_prev = 0;
  bit           hold_prev = 0;
  logic [W-1:0] held;
  logic [W-1:0] e_beat;
  int           beat_cnt  = 0;
  int           done_cnt  = 0;

  always @(negedge clk) begin
    if (!mon_en || rst) begin
      last_prev = 0;
      hold_prev = 0;
    end else begin
      chk("done_pulse", done_o, last_prev);
      if (last_prev) begin
        chk("done_valid", out_valid, 0);
        chk("done_busy", busy_o, 1);
      end
      if (out_valid) chk("busy_stream", busy_o, 1);
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_beat", {out_data, out_row, out_col, out_last}, held);
      end
      last_prev = 0;
      hold_prev = 0;
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          chk("extra_beat", exp_q.size(), 1);
        end else begin
          e_beat = exp_q.pop_front();
          chk("beat", {out_data, out_row, out_col, out_last}, e_beat);
          last_prev = e_beat[0];
        end
      end else if (out_valid) begin
        hold_prev = 1;
        held = {out_data, out_row, out_col, out_last};
      end
      if (done_o) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic bit pick_ready(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return (n % 3) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // Called just after a rising edge; returns just after the load edge.
  task automatic start_pass();
    apply_sums();
    push_pass();
    load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
  endtask

  // Drives out_ready until done_o has been seen; returns in the IDLE cycle.
  task automatic run_until_done(input int mode);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 200) begin
      out_ready = pick_ready(mode, n);
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == start) chk("timeout_done", done_cnt - start, 1);
  endtask

  task automatic set_incr_sums();
    for (int k = 0; k < N*N; k++) cur_sums[k] = SW'(k + 1);
  endtask

  // ---------------- cycle table for the basic pass ----------------
  typedef struct {
    bit            load;
    bit            ready;
    bit            valid;
    logic [SW-1:0] data;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    bit            last;
    bit            busy;
    bit            done;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int b0;
    int td[9];
    int tr[9];
    int tc[9];

`ifdef PE_DRAIN_COLMAJOR_EN
    td = '{1, 4, 7, 2, 5, 8, 3, 6, 9};
    tr = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    tc = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
`else
    td = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    tr = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    tc = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
`endif
    for (int i = 0; i < 9; i++) begin
      tbl[i] = '{load: (i == 0), ready: 1'b1, valid: 1'b1, data: SW'(td[i]),
                 row: IW'(tr[i]), col: IW'(tc[i]), last: (i == 8),
                 busy: 1'b1, done: 1'b0};
    end
    tbl[9]  = '{load: 1'b0, ready: 1'b1, valid: 1'b0, data: '0, row: '0, col: '0,
                last: 1'b0, busy: 1'b1, done: 1'b1};
    tbl[10] = '{load: 1'b0, ready: 1'b0, valid: 1'b0, data: '0, row: '0, col: '0,
                last: 1'b0, busy: 1'b0, done: 1'b0};

    // ---- reset ----
    rst = 1'b1; load_i = 1'b0; out_ready = 1'b0;
    set_incr_sums();
    apply_sums();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data,  0);
    chk("rst_row",   out_row,   0);
    chk("rst_col",   out_col,   0);
    chk("rst_last",  out_last,  0);
    chk("rst_busy",  busy_o,    0);
    chk("rst_done",  done_o,    0);
    rst = 1'b0;

    // ---- basic pass from the table ----
    for (int i = 0; i < 11; i++) begin
      load_i    = tbl[i].load;
      out_ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_last",  i), out_last,  tbl[i].last);
      chk($sformatf("tbl%0d_busy",  i), busy_o,    tbl[i].busy);
      chk($sformatf("tbl%0d_done",  i), done_o,    tbl[i].done);
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_data", i), out_data, tbl[i].data);
        chk($sformatf("tbl%0d_row",  i), out_row,  tbl[i].row);
        chk($sformatf("tbl%0d_col",  i), out_col,  tbl[i].col);
      end
    end

    @(posedge clk); #1;
    mon_en = 1;

    // ---- back-pressure 1,0,0,... ----
    b0 = beat_cnt;
    set_incr_sums();
    start_pass();
    run_until_done(1);
    chk("bp_beats", beat_cnt - b0, 9);
    chk("bp_left", exp_q.size(), 0);

    // ---- full-width data, input changes after load ----
    for (int k = 0; k < N*N; k++) cur_sums[k] = '1;
    start_pass();
    sums_i = '0;
    run_until_done(2);
    chk("fw_left", exp_q.size(), 0);

    // ---- load while busy, then held load starts a second pass ----
    b0 = beat_cnt;
    set_incr_sums();
    start_pass();
    repeat (3) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    for (int k = 0; k < N*N; k++) cur_sums[k] = SW'(((k + 3) * 37) & 9'h1FF);
    apply_sums();
    push_pass();
    load_i = 1'b1;
    run_until_done(0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
    run_until_done(0);
    chk("lwb_beats", beat_cnt - b0, 18);
    chk("lwb_left", exp_q.size(), 0);

    // ---- reset mid-stream after 5 beats ----
    b0 = beat_cnt;
    for (int k = 0; k < N*N; k++) cur_sums[k] = SW'($urandom_range(0, 511));
    start_pass();
    repeat (5) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rms_beats", beat_cnt - b0, 5);
    exp_q.delete();
    @(negedge clk);
    chk("rms_valid", out_valid, 0);
    chk("rms_busy",  busy_o,    0);
    chk("rms_done",  done_o,    0);
    repeat (3) @(posedge clk);
    #1;
    set_incr_sums();
    start_pass();
    run_until_done(0);
    chk("rms_left", exp_q.size(), 0);

    // ---- randomized passes ----
    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < N*N; k++) cur_sums[k] = SW'($urandom_range(0, 511));
      start_pass();
      run_until_done(int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    chk("rand_left", exp_q.size(), 0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
